// File: rtl/serdes_rx_deframer.sv
// Serial frame receiver: start / MSB-first data / optional even parity / stop,
// with error screening and a small output FIFO drained by a valid/ready handshake.
module serdes_rx_deframer #(
    parameter int DATA_W     = 8,
    parameter int PARITY_EN  = 1,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ser_en,
    input  logic              ser_in,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overflow,
    output logic              busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(DATA_W) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t            state_r, state_nx_s;
    logic [DATA_W-1:0] shreg_r;
    logic [CW-1:0]     cnt_r;
    logic              par_bad_r;
    logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
    logic [AW-1:0]     wptr_r, rptr_r;
    logic [AW:0]       count_r;
    logic              parity_err_r, frame_err_r, overflow_r;
    logic              stop_smp_s, good_s, pop_s, full_s, push_s, ovf_s, perr_s, ferr_s;

    // Nonzero when data plus parity bit do not XOR to zero
    function automatic logic even_par_bad(input logic [DATA_W-1:0] d, input logic p);
        return (^d) ^ p;
    endfunction

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_nx_s;
    end

    // FSM next-state: advances only on bit strobes
    always_comb begin
        state_nx_s = state_r;
        if (ser_en) begin
            case (state_r)
                IDLE: begin
                    if (!ser_in) state_nx_s = DATA;
                    else         state_nx_s = IDLE;
                end
                DATA: begin
                    if (cnt_r != LAST_BIT)   state_nx_s = DATA;
                    else if (PARITY_EN != 0) state_nx_s = PARITY;
                    else                     state_nx_s = STOP;
                end
                PARITY:  state_nx_s = STOP;
                STOP:    state_nx_s = IDLE;
                default: state_nx_s = IDLE;
            endcase
        end else begin
            state_nx_s = state_r;
        end
    end

    // Shift register, bit counter and latched parity verdict
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_r   <= {DATA_W{1'b0}};
            cnt_r     <= {CW{1'b0}};
            par_bad_r <= 1'b0;
        end else if (ser_en) begin
            case (state_r)
                IDLE:    cnt_r <= {CW{1'b0}};
                DATA: begin
                    shreg_r <= {shreg_r[DATA_W-2:0], ser_in};
                    cnt_r   <= cnt_r + CW'(1);
                end
                PARITY:  par_bad_r <= even_par_bad(shreg_r, ser_in);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // A bad stop bit outranks a parity error; a full FIFO only matters for good bytes
    assign stop_smp_s = ser_en && (state_r == STOP);
    assign pop_s      = (|count_r) && rx_ready;
    assign full_s     = (count_r == FULL_CNT);
    assign ferr_s     = stop_smp_s && !ser_in;
    assign perr_s     = stop_smp_s && ser_in && par_bad_r;
    assign good_s     = stop_smp_s && ser_in && !par_bad_r;
    assign ovf_s      = good_s && full_s && !pop_s;
    assign push_s     = good_s && !(full_s && !pop_s);

    // Output FIFO storage, pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= {DATA_W{1'b0}};
            wptr_r  <= {AW{1'b0}};
            rptr_r  <= {AW{1'b0}};
            count_r <= {(AW + 1){1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wptr_r] <= shreg_r;
                wptr_r        <= wptr_r + AW'(1);
            end
            if (pop_s) rptr_r <= rptr_r + AW'(1);
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (AW + 1)'(1);
                2'b01:   count_r <= count_r - (AW + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // One-cycle error pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_err_r <= 1'b0;
            frame_err_r  <= 1'b0;
            overflow_r   <= 1'b0;
        end else begin
            parity_err_r <= perr_s;
            frame_err_r  <= ferr_s;
            overflow_r   <= ovf_s;
        end
    end

    assign rx_data    = mem_r[rptr_r];
    assign rx_valid   = |count_r;
    assign parity_err = parity_err_r;
    assign frame_err  = frame_err_r;
    assign overflow   = overflow_r;
    assign busy       = (state_r != IDLE);

endmodule

// File: doc/serdes_rx_deframer.md
Name: serdes_rx_deframer

Overview:
Receive-side counterpart of the serializer path. Samples a framed serial bitstream on ser_in, one bit per ser_en strobe. Checks start, parity and stop bits, then rebuilds parallel bytes. Completed bytes go into a small FIFO, and the core logic pops them through a valid/ready handshake. Sits between the serial input pin and the parallel consumer, in the same clock domain.

Parameters:
DATA_W, 8, payload bits per frame
PARITY_EN, 1, 1 = an even-parity bit follows the data; 0 = no parity bit
FIFO_DEPTH, 2, output FIFO entries; must be a power of 2 and at least 2

Ports:
clk  input  1  single clock; all logic on the rising edge
rst  input  1  reset, asynchronous, active-high; clears all state immediately
ser_en  input  1  bit strobe; ser_in is sampled only in cycles where ser_en=1
ser_in  input  1  serial line; idles high
rx_data  output  DATA_W  head-of-FIFO byte
rx_valid  output  1  FIFO not empty
rx_ready  input  1  consumer accepts rx_data when rx_valid && rx_ready
parity_err  output  1  one-cycle pulse: parity mismatch, byte discarded
frame_err  output  1  one-cycle pulse: stop bit sampled 0, byte discarded
overflow  output  1  one-cycle pulse: good byte arrived while FIFO full, byte discarded
busy  output  1  FSM not in IDLE

Behaviour:
- Reset values: rx_data=0, rx_valid=0, parity_err=0, frame_err=0, overflow=0, busy=0. FIFO is emptied and FSM goes to IDLE.
- Frame format, MSB first: start(0), D[DATA_W-1]..D[0], parity (if PARITY_EN), stop(1).
- Even parity: the XOR of the data bits and the parity bit must equal 0.
- FSM states: IDLE, DATA, PARITY, STOP. Transitions happen only in cycles with ser_en=1; with ser_en=0 all state holds.
- IDLE: ser_in=0 -> DATA, bit counter=0. ser_in=1 -> stay in IDLE.
- DATA:
  - Shift: shreg <= {shreg[DATA_W-2:0], ser_in}; counter increments.
  - After DATA_W samples -> PARITY if PARITY_EN, else STOP.
- PARITY: sample the parity bit, store the mismatch flag -> STOP.
- STOP: sample the stop bit -> IDLE. Then apply the checks in priority order:
  1. ser_in=0: frame_err pulse next cycle; byte dropped.
  2. Else parity mismatch: parity_err pulse next cycle; byte dropped.
  3. Else FIFO full (after any same-cycle pop): overflow pulse next cycle; byte dropped.
  4. Else: push the byte.
- Back-to-back frames: the stop-bit cycle always returns to IDLE. The next start bit is detected on the following ser_en strobe, so no idle bit is needed between frames.
- Latency: a pushed byte appears with rx_valid=1 in the cycle after the stop-bit sample, provided the FIFO was empty.
- FIFO:
  - Circular buffer with read/write pointers and a count of width $clog2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.
  - Pop occurs on rx_valid && rx_ready.
  - rx_data is driven combinationally from the head entry.
  - Push and pop in the same cycle: both happen and the count is unchanged. When full, a same-cycle pop frees a slot, so the push succeeds and no overflow is reported.
  - Pop when empty is ignored; rx_ready is don't-care while rx_valid=0.
  - rx_data and rx_valid stay stable while rx_valid=1 && rx_ready=0.
- Error pulses last exactly one cycle; at most one of the three fires per frame.
- busy=1 in DATA, PARITY and STOP.
- Reset mid-frame: the partial frame is discarded and the FIFO contents are lost. After rst deasserts, the first ser_en strobe is treated from IDLE.
- Glitch start (ser_in=0 for one strobe, then 1s) is not filtered: it is received as a frame and normally ends in parity_err or frame_err.

Test Plan:
- Byte 0xA5, parity 0, stop 1, ser_en=1 every cycle, rx_ready=1 -> rx_valid pulses one cycle with rx_data=0xA5; no error pulse.
- Byte 0x3C sent with ser_en=1 only every 4th cycle -> rx_data=0x3C; busy=1 from the start bit until the stop-bit sample; every other output identical to the full-rate run.
- Byte 0x01 with parity bit 0 -> parity_err pulses once, rx_valid stays 0. Byte 0x80 with stop bit 0 -> frame_err pulses once, parity_err stays 0.
- rx_ready=0; send 0x11, 0x22, 0x33 back-to-back -> FIFO holds 0x11, 0x22; overflow pulses on 0x33. Then rx_ready=1 -> reads 0x11 then 0x22, then rx_valid=0.
- FIFO full (0x11, 0x22) and rx_ready=1 in the exact cycle 0x44 completes -> no overflow; later read order is 0x22, 0x44.
- rst asserted after 4 data bits of 0xF0, with one byte 0x55 queued -> rx_valid=0 and busy=0 immediately; the next full frame 0x0F is received correctly.
